secded_decoder: RTL and testbench



---
 rtl/secded_pkg.sv | 10 +
 rtl/secded_if.sv | 6 +
 rtl/secded_syndrome.sv | 23 ++
 rtl/secded_decoder.sv | 59 +++++
 tb/tb_secded_decoder.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/secded_pkg.sv
// secded_pkg: geometry constants and FSM state type for the (16,11) extended Hamming SECDED code
package secded_pkg;
  localparam int CW_LEN = 16;
  localparam int DATA_LEN = 11;
  localparam int SYN_W = 4;
  localparam int PAR_LEN = CW_LEN - DATA_LEN;
  localparam logic [SYN_W-1:0] PAR_POS [PAR_LEN] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8};
  localparam logic [SYN_W-1:0] DATA_POS [DATA_LEN] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
endpackage

// File: rtl/secded_if.sv
// secded_if: serial link bundle; datain/validin/sofin toward the decoder, dataout/validout/err_single/err_double back
interface secded_if;
  logic datain, validin, sofin, dataout, validout, err_single, err_double;
  modport master (output datain, validin, sofin, input dataout, validout, err_single, err_double);
  modport slave (input datain, validin, sofin, output dataout, validout, err_single, err_double);
endinterface

// File: rtl/secded_syndrome.sv
// secded_syndrome: combinational check of one codeword; cw in, syndrome s, overall parity p, corrected data, err_single/err_double out
module secded_syndrome import secded_pkg::*; (
  input  logic [CW_LEN-1:0]   cw,
  output logic [SYN_W-1:0]    s,
  output logic                p,
  output logic [DATA_LEN-1:0] data,
  output logic                err_single,
  output logic                err_double
);
  logic [CW_LEN-1:0] fixed;
  always_comb begin
    s = '0;
    for (int b = 0; b < SYN_W; b++)
      for (int j = 1; j < CW_LEN; j++)
        s[b] = s[b] ^ (cw[j] & |(SYN_W'(j) & PAR_POS[b+1]));
    p = ^cw;
    fixed = cw ^ (CW_LEN'(p) << s);
    data = '0;
    for (int i = 0; i < DATA_LEN; i++) data[i] = fixed[DATA_POS[i]];
    err_single = p;
    err_double = !p && |s;
  end
endmodule

// File: rtl/secded_decoder.sv
// secded_decoder: serial (16,11) SECDED receiver; clk, rst_n, bus.slave (datain/validin/sofin in; dataout/validout/err_single/err_double out)
module secded_decoder import secded_pkg::*; (
  input logic     clk,
  input logic     rst_n,
  secded_if.slave bus
);
  logic [3:0] cnt, pos, k;
  logic [CW_LEN-1:0] sr, hold, cw_in;
  logic [DATA_LEN-1:0] out, data_fix;
  logic [SYN_W-1:0] unused_s;
  logic unused_p, done, pend, err_s, err_d, s_single, s_double;
  state_t state, nxt;
  assign pos = bus.sofin ? '0 : cnt;
  assign cw_in = {bus.datain, sr[CW_LEN-1:1]};
  assign done = bus.validin && &pos;
  secded_syndrome u_syn (
    .cw(hold), .s(unused_s), .p(unused_p), .data(data_fix),
    .err_single(s_single), .err_double(s_double)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sr <= '0;
      hold <= '0;
      pend <= 1'b0;
    end else begin
      if (bus.validin) begin
        cnt <= pos + 4'd1;
        sr <= cw_in;
      end
      if (done) hold <= cw_in;
      pend <= done || (pend && state != LOAD);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? ((done || pend) ? LOAD : IDLE) :
          state == LOAD ? SHIFT : (k == 4'd10 ? IDLE : SHIFT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out <= '0;
      k <= '0;
      err_s <= 1'b0;
      err_d <= 1'b0;
    end else if (state == LOAD) begin
      out <= data_fix;
      k <= '0;
      err_s <= s_single;
      err_d <= s_double;
    end else if (state == SHIFT) begin
      out <= out >> 1;
      k <= k + 4'd1;
    end
  assign bus.validout = state == SHIFT;
  assign bus.dataout = bus.validout & out[0];
  assign bus.err_single = err_s;
  assign bus.err_double = err_d;
endmodule

// File: tb/tb_secded_decoder.sv
// tb_secded_decoder: scoreboard bench for the serial SECDED decoder
module tb_secded_decoder;
  typedef struct packed {logic d; logic es; logic ed; int c;} smp_t;
  localparam int DP [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int ri = 0;
  smp_t obs_q[$];
  smp_t exp_q[$];
  secded_if bus();
  secded_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (bus.validout) obs_q.push_back({bus.dataout, bus.err_single, bus.err_double, cyc});
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < 11; i++) c[DP[i]] = d[i];
    for (int b = 0; b < 4; b++)
      for (int j = 3; j < 16; j++)
        if (j[b] && j != (1 << b)) c[1 << b] = c[1 << b] ^ c[j];
    c[0] = ^c[15:1];
    return c;
  endfunction
  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    for (int i = 0; i < 11; i++) d[i] = c[DP[i]];
    return d;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic d, input logic v, input logic s);
    @(negedge clk);
    bus.datain = d;
    bus.validin = v;
    bus.sofin = s;
  endtask
  task automatic send(input logic [15:0] cw, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      drive(cw[i], 1'b1, i == 0);
    end
  endtask
  task automatic frame(input logic [15:0] cw, input logic [10:0] d, input logic es, input logic ed, input bit gaps);
    smp_t e;
    send(cw, 16, gaps);
    for (int k = 0; k < 11; k++) begin
      e = {d[k], es, ed, cyc + 2 + k};
      exp_q.push_back(e);
    end
  endtask
  task automatic check_all(input string tag);
    int n;
    smp_t e, o;
    n = ri + exp_q.size();
    for (int t = 0; t < 80 && obs_q.size() < n; t++) @(negedge clk);
    check({tag, "_count"}, obs_q.size(), n);
    while (exp_q.size() > 0 && ri < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[ri];
      ri++;
      check({tag, "_data"}, o.d, e.d);
      check({tag, "_single"}, o.es, e.es);
      check({tag, "_double"}, o.ed, e.ed);
      check({tag, "_cycle"}, o.c, e.c);
    end
    exp_q.delete();
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_dataout"}, bus.dataout, 0);
    check({tag, "_validout"}, bus.validout, 0);
    check({tag, "_err_single"}, bus.err_single, 0);
    check({tag, "_err_double"}, bus.err_double, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] cw;
    logic [10:0] d;
    int i, j;
    bus.datain = 1'b0;
    bus.validin = 1'b0;
    bus.sofin = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    frame(encode(11'd0), 11'd0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0);
    check_all("zero");
    cw = encode(11'd1);
    check("enc_pos3", cw, 16'h000f);
    frame(cw, 11'd1, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0);
    check_all("pos3");
    frame(cw ^ 16'h0400, 11'd1, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0);
    check_all("flip10");
    frame(cw ^ 16'h0001, 11'd1, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0);
    check_all("flip0");
    check("hold_single", bus.err_single, 1);
    cw = encode(11'd0) | 16'h0060;
    frame(cw, extract(cw), 1'b0, 1'b1, 1'b0);
    drive(0, 0, 0);
    check_all("double56");
    check("dbl_bits", extract(cw), 11'b110);
    check("hold_double", bus.err_double, 1);
    d = 11'($urandom);
    i = $urandom_range(0, 15);
    frame(encode(d) ^ (16'd1 << i), d, 1'b1, 1'b0, 1'b1);
    drive(0, 0, 0);
    check_all("gaps");
    d = 11'($urandom);
    frame(encode(d), d, 1'b0, 1'b0, 1'b0);
    d = 11'($urandom);
    i = $urandom_range(0, 15);
    j = (i + 1 + $urandom_range(0, 14)) % 16;
    cw = encode(d) ^ (16'd1 << i) ^ (16'd1 << j);
    frame(cw, extract(cw), 1'b0, 1'b1, 1'b0);
    drive(0, 0, 0);
    check_all("b2b");
    send(encode(11'h5a5), 9, 1'b0);
    @(negedge clk);
    bus.validin = 1'b0;
    rst_n = 1'b0;
    #1;
    check_quiet("rst_pos9");
    @(negedge clk);
    rst_n = 1'b1;
    d = 11'h2b6;
    frame(encode(d), d, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0);
    check_all("after_rst");
    d = 11'h1c3;
    frame(encode(d) ^ 16'h0100, d, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0);
    for (int t = 0; t < 40 && obs_q.size() < ri + 4; t++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_quiet("rst_out");
    exp_q.delete();
    @(negedge clk);
    ri = obs_q.size();
    rst_n = 1'b1;
    d = 11'h3f0;
    frame(encode(d), d, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0);
    check_all("after_rst_out");
    send(encode(11'h7ff), 7, 1'b0);
    d = 11'h04d;
    frame(encode(d), d, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0);
    check_all("sof_restart");
    repeat (30) @(negedge clk);
    check("no_extra_bits", obs_q.size(), ri);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
